// File: rtl/cnt5_chk_pkg.sv
// Shared constants, state encoding and helpers for the mod-5 counter checker.
// Holds the modulus, maximum count, counter width, saturation value and FSM states.
package cnt5_chk_pkg;

   localparam int unsigned          MOD_N   = 5;
   localparam logic [2:0]           MAX_CNT = 3'd4;
   localparam int unsigned          CNT_W   = 8;
   localparam logic [CNT_W-1:0]     SAT_VAL = 8'd255;
   localparam logic [2:0]           BAD_DEC = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FAIL = 2'd2
   } state_t;

   function automatic logic [2:0] cnt_next(input logic [2:0] cur);
      return (cur == MAX_CNT) ? 3'd0 : cur + 3'd1;
   endfunction

   function automatic logic [MOD_N-1:0] bin2oh(input logic [2:0] b);
      logic [MOD_N-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < MOD_N; i++) begin
         if (b == 3'(i)) r[i] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/cnt5_chk_oh2bin5.sv
// Combinational 5-bit one-hot to 3-bit binary decoder with a validity flag.
// Any code without exactly one bit set decodes to BAD_DEC with valid low.
module oh2bin5
   import cnt5_chk_pkg::*;
(
   input  logic [MOD_N-1:0] oh,
   output logic [2:0]       bin,
   output logic             valid
);

   logic [2:0] idx;
   logic [2:0] ones;

   always_comb begin
      idx  = '0;
      ones = '0;
      for (int unsigned i = 0; i < MOD_N; i++) begin
         if (oh[i]) begin
            idx  = 3'(i);
            ones = ones + 3'd1;
         end
      end
      valid = (ones == 3'd1);
      bin   = valid ? idx : BAD_DEC;
   end

endmodule

// File: rtl/cnt5_chk.sv
// Checker for a pair of mod-5 counters (binary and one-hot) driven by a shared inc.
// Tracks an internal reference count, registers per-cycle error flags and a sticky FAIL state.
module cnt5_chk
   import cnt5_chk_pkg::*;
(
   input  logic             clk,
   input  logic             rb,
   input  logic             inc,
   input  logic             en,
   input  logic [2:0]       c_b,
   input  logic [MOD_N-1:0] c_o,
   output logic [2:0]       dec_o,
   output logic             err_b,
   output logic             err_o,
   output logic             err_oh,
   output logic             err_x,
   output logic             fail,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] wrap_cnt,
   output logic [2:0]       exp_b
);

   state_t     state, state_nxt;
   logic [2:0] dec;
   logic       oh_valid;
   logic       e_b, e_o, e_oh, e_x;
   logic       any_err;

   oh2bin5 u_oh2bin5 (
      .oh    (c_o),
      .bin   (dec),
      .valid (oh_valid)
   );

   // All compares use the pre-update reference count.
   always_comb begin
      e_b     = (c_b != exp_b);
      e_o     = (c_o != bin2oh(exp_b));
      e_oh    = !oh_valid;
      e_x     = oh_valid && (dec != c_b);
      any_err = en && (e_b || e_o || e_oh || e_x);
   end

   // An error seen while leaving IDLE goes straight to FAIL so that fail rises
   // together with the first registered error flag.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (en) state_nxt = any_err ? ST_FAIL : ST_RUN;
         ST_RUN: begin
            if (any_err)  state_nxt = ST_FAIL;
            else if (!en) state_nxt = ST_IDLE;
         end
         ST_FAIL: state_nxt = ST_FAIL;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rb) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   assign fail = (state == ST_FAIL);

   always_ff @(posedge clk) begin
      if (!rb) begin
         exp_b    <= '0;
         dec_o    <= '0;
         err_b    <= 1'b0;
         err_o    <= 1'b0;
         err_oh   <= 1'b0;
         err_x    <= 1'b0;
         err_cnt  <= '0;
         wrap_cnt <= '0;
      end else begin
         if (inc) exp_b <= cnt_next(exp_b);
         if (inc && (exp_b == MAX_CNT)) wrap_cnt <= wrap_cnt + 8'd1;
         dec_o  <= dec;
         err_b  <= en && e_b;
         err_o  <= en && e_o;
         err_oh <= en && e_oh;
         err_x  <= en && e_x;
         if (any_err && (err_cnt != SAT_VAL)) err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_cnt5_chk.sv
// Directed self-checking bench for cnt5_chk: a hand-computed vector table plus
// sequences for connected-counter runs, wrap counting and err_cnt saturation.
module tb_cnt5_chk;

   logic       clk = 1'b0;
   logic       rb, inc, en;
   logic [2:0] c_b;
   logic [4:0] c_o;
   logic [2:0] dec_o, exp_b;
   logic       err_b, err_o, err_oh, err_x, fail;
   logic [7:0] err_cnt, wrap_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cnt5_chk dut (
      .clk      (clk),
      .rb       (rb),
      .inc      (inc),
      .en       (en),
      .c_b      (c_b),
      .c_o      (c_o),
      .dec_o    (dec_o),
      .err_b    (err_b),
      .err_o    (err_o),
      .err_oh   (err_oh),
      .err_x    (err_x),
      .fail     (fail),
      .err_cnt  (err_cnt),
      .wrap_cnt (wrap_cnt),
      .exp_b    (exp_b)
   );

   typedef struct {
      logic       rb, inc, en;
      logic [2:0] c_b;
      logic [4:0] c_o;
      logic [2:0] x_exp, x_dec;
      logic       x_eb, x_eo, x_eoh, x_ex, x_fail;
      logic [7:0] x_ecnt, x_wrap;
   } vec_t;

   vec_t vt[18];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic step(input logic r, input logic i, input logic e,
                       input logic [2:0] b, input logic [4:0] o);
      rb = r; inc = i; en = e; c_b = b; c_o = o;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic r, input logic i, input logic e,
                               input logic [2:0] b, input logic [4:0] o,
                               input logic [2:0] xe, input logic [2:0] xd,
                               input logic eb, input logic eo, input logic eoh,
                               input logic ex, input logic f,
                               input logic [7:0] ec, input logic [7:0] wc);
      vec_t v;
      v.rb = r; v.inc = i; v.en = e; v.c_b = b; v.c_o = o;
      v.x_exp = xe; v.x_dec = xd; v.x_eb = eb; v.x_eo = eo; v.x_eoh = eoh;
      v.x_ex = ex; v.x_fail = f; v.x_ecnt = ec; v.x_wrap = wc;
      return v;
   endfunction

   initial begin
      logic [2:0] tb_b;
      logic [4:0] tb_o;

      //            rb inc en c_b   c_o        exp dec eb eo eoh ex fail ecnt wrap
      vt[0]  = mk(0, 1, 1, 3'd0, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[1]  = mk(0, 1, 1, 3'd0, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[2]  = mk(1, 1, 1, 3'd0, 5'b00001, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[3]  = mk(1, 1, 1, 3'd1, 5'b00010, 2, 1, 0, 0, 0, 0, 0, 0, 0);
      vt[4]  = mk(1, 1, 1, 3'd2, 5'b00100, 3, 2, 0, 0, 0, 0, 0, 0, 0);
      vt[5]  = mk(1, 1, 1, 3'd3, 5'b01000, 4, 3, 0, 0, 0, 0, 0, 0, 0);
      vt[6]  = mk(1, 1, 1, 3'd4, 5'b10000, 0, 4, 0, 0, 0, 0, 0, 0, 1);
      vt[7]  = mk(1, 0, 1, 3'd0, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      vt[8]  = mk(1, 0, 0, 3'd5, 5'b00000, 0, 7, 0, 0, 0, 0, 0, 0, 1);
      vt[9]  = mk(1, 1, 1, 3'd0, 5'b00001, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      vt[10] = mk(1, 0, 1, 3'd1, 5'b00011, 1, 7, 0, 1, 1, 0, 1, 1, 1);
      vt[11] = mk(1, 1, 1, 3'd1, 5'b00010, 2, 1, 0, 0, 0, 0, 1, 1, 1);
      vt[12] = mk(1, 0, 1, 3'd6, 5'b00100, 2, 2, 1, 0, 0, 1, 1, 2, 1);
      vt[13] = mk(1, 1, 0, 3'd6, 5'b00100, 3, 2, 0, 0, 0, 0, 1, 2, 1);
      vt[14] = mk(1, 1, 1, 3'd3, 5'b01000, 4, 3, 0, 0, 0, 0, 1, 2, 1);
      vt[15] = mk(1, 1, 1, 3'd0, 5'b10000, 0, 4, 1, 0, 0, 1, 1, 3, 2);
      vt[16] = mk(0, 1, 1, 3'd2, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[17] = mk(1, 1, 1, 3'd0, 5'b00001, 1, 0, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 18; i++) begin
         step(vt[i].rb, vt[i].inc, vt[i].en, vt[i].c_b, vt[i].c_o);
         chk($sformatf("v%0d exp_b", i),    8'(exp_b),    8'(vt[i].x_exp));
         chk($sformatf("v%0d dec_o", i),    8'(dec_o),    8'(vt[i].x_dec));
         chk($sformatf("v%0d err_b", i),    8'(err_b),    8'(vt[i].x_eb));
         chk($sformatf("v%0d err_o", i),    8'(err_o),    8'(vt[i].x_eo));
         chk($sformatf("v%0d err_oh", i),   8'(err_oh),   8'(vt[i].x_eoh));
         chk($sformatf("v%0d err_x", i),    8'(err_x),    8'(vt[i].x_ex));
         chk($sformatf("v%0d fail", i),     8'(fail),     8'(vt[i].x_fail));
         chk($sformatf("v%0d err_cnt", i),  err_cnt,      vt[i].x_ecnt);
         chk($sformatf("v%0d wrap_cnt", i), wrap_cnt,     vt[i].x_wrap);
      end

      // Connected counters: 2 reset clocks then 12 increments.
      step(0, 0, 0, 3'd0, 5'b00001);
      step(0, 0, 0, 3'd0, 5'b00001);
      tb_b = 3'd0; tb_o = 5'b00001;
      for (int i = 0; i < 12; i++) begin
         step(1, 1, 1, tb_b, tb_o);
         tb_b = (tb_b == 3'd4) ? 3'd0 : tb_b + 3'd1;
         tb_o = {tb_o[3:0], tb_o[4]};
         chk($sformatf("s1 exp_b %0d", i), 8'(exp_b), 8'(tb_b));
         chk($sformatf("s1 errs %0d", i), 8'({err_b, err_o, err_oh, err_x, fail}), 8'd0);
      end
      chk("s1 wrap_cnt", wrap_cnt, 8'd2);
      for (int i = 0; i < 7; i++) begin
         step(1, 0, 1, tb_b, tb_o);
         chk($sformatf("s2 exp_b %0d", i), 8'(exp_b), 8'd2);
         chk($sformatf("s2 errs %0d", i), 8'({err_b, err_o, err_oh, err_x, fail}), 8'd0);
      end
      chk("s2 wrap_cnt", wrap_cnt, 8'd2);

      // wrap_cnt counts regardless of en and wraps 255 -> 0.
      step(0, 0, 0, 3'd0, 5'b00001);
      for (int i = 0; i < 1280; i++) step(1, 1, 0, 3'd7, 5'b11111);
      chk("wrap 256", wrap_cnt, 8'd0);
      chk("wrap err_cnt", err_cnt, 8'd0);
      for (int i = 0; i < 5; i++) step(1, 1, 0, 3'd7, 5'b11111);
      chk("wrap 257", wrap_cnt, 8'd1);

      // err_cnt saturation with c_b held at an illegal value.
      step(0, 0, 0, 3'd0, 5'b00001);
      for (int i = 1; i <= 300; i++) begin
         step(1, 0, 1, 3'd5, 5'b00001);
         if (i == 1)   chk("sat first", err_cnt, 8'd1);
         if (i == 254) chk("sat 254", err_cnt, 8'd254);
         if (i == 255) chk("sat 255", err_cnt, 8'd255);
         if (i == 256) chk("sat hold", err_cnt, 8'd255);
      end
      chk("sat end", err_cnt, 8'd255);
      chk("sat err_b", 8'(err_b), 8'd1);
      chk("sat fail", 8'(fail), 8'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
